vm2002_ctrl: RTL

VM2002_CTRL -- requirements
Module: vm2002_ctrl

---
 rtl/vm2002_ctrl.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vm2002_ctrl.sv
// vm2002_ctrl: coin vending controller (credit in nickels, per-item stock, registered outputs).
// Build option: define VM2002_CHANGE_EN to compile in the CHANGE state and greedy coin return.
module vm2002_ctrl #(
  parameter int MAX_CREDIT = 60,
  parameter int STOCK_INIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin,
  input  logic       select_valid,
  input  logic [2:0] select,
  input  logic       cancel,
  input  logic       restock,
  output logic       coin_reject,
  output logic       dispense_valid,
  output logic [2:0] dispense_item,
  output logic       change_valid,
  output logic [1:0] change_coin,
  output logic [7:0] credit,
  output logic [1:0] status,
  output logic       busy
);

  localparam logic [1:0] NICKEL      = 2'd0;
  localparam logic [1:0] DIME        = 2'd1;
  localparam logic [1:0] QUARTER     = 2'd2;
  localparam logic [1:0] ILLEGALCOIN = 2'd3;

  localparam logic [1:0] AVAILABE    = 2'd0;
  localparam logic [1:0] UNAVAILABLE = 2'd1;
  localparam logic [1:0] ERROR       = 2'd2;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CREDIT   = 2'd1;
  localparam logic [1:0] DISPENSE = 2'd2;
`ifdef VM2002_CHANGE_EN
  localparam logic [1:0] CHANGE   = 2'd3;
`endif

  localparam logic [7:0] MAX_C     = 8'(MAX_CREDIT);
  localparam logic [3:0] STOCK_RST = 4'(STOCK_INIT);

  function automatic logic [7:0] coinValue(input logic [1:0] c);
    logic [7:0] v;
    v = 8'd0;
    case (c)
      NICKEL:      v = 8'd1;
      DIME:        v = 8'd2;
      QUARTER:     v = 8'd5;
      ILLEGALCOIN: v = 8'd0;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] itemCost(input logic [2:0] item);
    logic [7:0] c;
    case (item)
      3'd0:                c = 8'd10;
      3'd1, 3'd2, 3'd3:    c = 8'd20;
      3'd4:                c = 8'd40;
      3'd5:                c = 8'd25;
      3'd6:                c = 8'd30;
      default:             c = 8'd35;
    endcase
    return c;
  endfunction

  logic [1:0] r_state;
  logic [7:0] r_credit;
  logic [1:0] r_status;
  logic [2:0] r_sel;
  logic       r_coinReject;
  logic       r_dispValid;
  logic       r_busy;
  logic [3:0] r_stock [8];

  logic [1:0] w_nextState;
  logic [7:0] w_nextCredit;
  logic [1:0] w_nextStatus;
  logic [2:0] w_nextSel;
  logic       w_coinReject;
  logic       w_dispValid;
  logic       w_stockDec;
  logic       w_busyNext;
  logic [7:0] w_coinVal;
  logic [8:0] w_coinSum;
  logic       w_coinOk;

  assign w_coinVal = coinValue(coin);
  assign w_coinSum = {1'b0, r_credit} + {1'b0, w_coinVal};
  assign w_coinOk  = (w_coinVal != 8'd0) && (w_coinSum <= {1'b0, MAX_C});

`ifdef VM2002_CHANGE_EN
  logic       r_changeValid;
  logic [1:0] r_changeCoin;
  logic       w_changeValid;
  logic [1:0] w_changeCoin;
  logic [1:0] w_greedyCoin;

  // Largest coin that still fits in the credit left to return.
  assign w_greedyCoin = (r_credit >= 8'd5) ? QUARTER :
                        (r_credit >= 8'd2) ? DIME : NICKEL;
`else
  logic w_unusedCancel;
  assign w_unusedCancel = cancel;
`endif

  always_comb begin
    w_nextState  = r_state;
    w_nextCredit = r_credit;
    w_nextStatus = r_status;
    w_nextSel    = r_sel;
    w_coinReject = 1'b0;
    w_dispValid  = 1'b0;
    w_stockDec   = 1'b0;
`ifdef VM2002_CHANGE_EN
    w_changeValid = 1'b0;
    w_changeCoin  = NICKEL;
`endif
    case (r_state)
      IDLE: begin
        if (coin_valid) begin
          if (w_coinOk) begin
            w_nextCredit = w_coinSum[7:0];
            w_nextState  = CREDIT;
          end else begin
            w_coinReject = 1'b1;
          end
        end
      end
      CREDIT: begin
        // cancel beats select beats coin; a coin that loses is bounced
`ifdef VM2002_CHANGE_EN
        if (cancel) begin
          w_coinReject  = coin_valid;
          w_nextState   = CHANGE;
          w_changeValid = 1'b1;
          w_changeCoin  = w_greedyCoin;
          w_nextCredit  = r_credit - coinValue(w_greedyCoin);
        end else
`endif
        if (select_valid) begin
          w_coinReject = coin_valid;
          if (r_stock[select] == 4'd0) begin
            w_nextStatus = UNAVAILABLE;
          end else if (r_credit < itemCost(select)) begin
            w_nextStatus = ERROR;
          end else begin
            w_nextState  = DISPENSE;
            w_nextSel    = select;
            w_nextCredit = r_credit - itemCost(select);
            w_stockDec   = 1'b1;
            w_dispValid  = 1'b1;
            w_nextStatus = AVAILABE;
          end
        end else if (coin_valid) begin
          if (w_coinOk) w_nextCredit = w_coinSum[7:0];
          else          w_coinReject = 1'b1;
        end
      end
      DISPENSE: begin
        w_coinReject = coin_valid;
        if (r_credit == 8'd0) begin
          w_nextState = IDLE;
        end else begin
`ifdef VM2002_CHANGE_EN
          w_nextState   = CHANGE;
          w_changeValid = 1'b1;
          w_changeCoin  = w_greedyCoin;
          w_nextCredit  = r_credit - coinValue(w_greedyCoin);
`else
          w_nextState = CREDIT;
`endif
        end
      end
`ifdef VM2002_CHANGE_EN
      CHANGE: begin
        w_coinReject = coin_valid;
        if (r_credit == 8'd0) begin
          w_nextState = IDLE;
        end else begin
          w_changeValid = 1'b1;
          w_changeCoin  = w_greedyCoin;
          w_nextCredit  = r_credit - coinValue(w_greedyCoin);
        end
      end
`endif
      default: w_nextState = IDLE;
    endcase
  end

`ifdef VM2002_CHANGE_EN
  assign w_busyNext = (w_nextState == DISPENSE) || (w_nextState == CHANGE);
`else
  assign w_busyNext = (w_nextState == DISPENSE);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_credit     <= 8'd0;
      r_status     <= AVAILABE;
      r_sel        <= 3'd0;
      r_coinReject <= 1'b0;
      r_dispValid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_credit     <= w_nextCredit;
      r_status     <= w_nextStatus;
      r_sel        <= w_nextSel;
      r_coinReject <= w_coinReject;
      r_dispValid  <= w_dispValid;
      r_busy       <= w_busyNext;
    end
  end

  // Restock reloads everything and overrides a decrement in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || restock) begin
      for (int k = 0; k < 8; k++) r_stock[k] <= STOCK_RST;
    end else if (w_stockDec) begin
      r_stock[w_nextSel] <= r_stock[w_nextSel] - 4'd1;
    end
  end

`ifdef VM2002_CHANGE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_changeValid <= 1'b0;
      r_changeCoin  <= NICKEL;
    end else begin
      r_changeValid <= w_changeValid;
      r_changeCoin  <= w_changeCoin;
    end
  end

  assign change_valid = r_changeValid;
  assign change_coin  = r_changeCoin;
`else
  assign change_valid = 1'b0;
  assign change_coin  = NICKEL;
`endif

  assign coin_reject    = r_coinReject;
  assign dispense_valid = r_dispValid;
  assign dispense_item  = r_sel;
  assign credit         = r_credit;
  assign status         = r_status;
  assign busy           = r_busy;

endmodule
